pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//   Central pipeline sequencer for the 5-stage core (pc, if_id, id_ex, ex_mem, mem_wb).
//   - Merges per-stage stall requests into the stall vector that holds the pc and stage registers.
//   - Sequences exception/redirect recovery: flush all stage registers, then steer the pc to the
//     handler address until fetch accepts it.
//   - Watchdog flags a stall that persists too long.
// PARAMETERS
//   FLUSH_CYCLES   1    cycles flush is held high per redirect (1..15)
//   STALL_TIMEOUT  255  consecutive stalled RUN cycles before stall_timeout pulses (1..255)
// PORTS
//   clk            in   1   core clock, rising edge
//   rst            in   1   asynchronous reset, active-low (0 = reset)
//   stallreq_if    in   1   fetch waiting on instruction memory
//   stallreq_id    in   1   load-use hazard in decode
//   stallreq_ex    in   1   multi-cycle op busy in execute
//   stallreq_mem   in   1   data memory wait
//   excp_req       in   1   exception/redirect request from mem stage, sampled each cycle
//   excp_pc        in   32  handler/target address, valid with excp_req
//   stall          out  6   [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]reserved(always 0)
//   flush          out  1   clear all stage registers to their reset value
//   new_pc         out  32  redirect address for the pc register
//   new_pc_valid   out  1   pc must load new_pc this cycle
//   stall_timeout  out  1   one-cycle pulse, watchdog expiry
//   busy           out  1   state != RUN
// BEHAVIOUR
//   - Reset (rst=0, async): state=RUN, flush cnt=0, stall cnt=0, new_pc=0.
//     All outputs are 0 while rst=0.
//   - Stall masks, combinational, 0-cycle latency, RUN state only:
//     if=6'b000011, id=000111, ex=001111, mem=011111. stall = OR of the masks of asserted requests.
//   - States: RUN, FLUSH, REDIR.
//   - RUN: stall per masks; flush=0, new_pc_valid=0.
//     excp_req=1 -> new_pc<=excp_pc, fcnt<=0, next FLUSH.
//     Stall masks still apply in the excp_req cycle.
//   - FLUSH: flush=1, stall=0, every request ignored (excp_req included).
//     fcnt increments each cycle; at fcnt==FLUSH_CYCLES-1 -> REDIR.
//     flush is high exactly FLUSH_CYCLES cycles, starting 1 cycle after excp_req.
//   - REDIR: new_pc_valid=1, flush=0, stall=0, excp_req ignored.
//     stallreq_if=1 -> stay in REDIR (new_pc held).
//     stallreq_if=0 -> RUN next cycle.
//     Minimum REDIR residency is 1 cycle.
//   - Watchdog: scnt (8 bit) increments on each RUN cycle with stall!=0; cleared on a RUN cycle with
//     stall==0 and on leaving RUN.
//     When scnt reaches STALL_TIMEOUT-1 while still stalled: stall_timeout=1 for that one cycle,
//     then scnt saturates. No further pulses until the stall clears.
//     The watchdog never alters stall.
//   - busy=1 in FLUSH and REDIR.
//   - rst=0 in any state: immediate return to RUN, pending redirect discarded.
// TESTING
//   1 Stall merge: stallreq_id=1 then stallreq_id=1+stallreq_mem=1
//     -> stall=000111 then 011111 in the same cycle; all 0 -> 000000.
//   2 Redirect: excp_req=1, excp_pc=32'h0000_0100, FLUSH_CYCLES=1
//     -> next cycle flush=1; following cycle new_pc_valid=1, new_pc=0x100; then RUN, busy=0.
//   3 Redirect with fetch wait: as 2 but stallreq_if=1 for 3 cycles in REDIR
//     -> new_pc_valid stays 1 for 3 cycles + 1; stall stays 0.
//   4 Ignored events: excp_req with pc 0x200 during FLUSH, stallreq_ex during FLUSH
//     -> new_pc stays 0x100, stall=0.
//   5 Watchdog: STALL_TIMEOUT=4, stallreq_ex high 10 cycles
//     -> single stall_timeout pulse on the 4th stalled cycle; drop for 1 cycle, re-raise
//     -> pulse again after 4 cycles.
//   6 Reset mid-FLUSH: rst=0 asynchronously
//     -> flush, busy, new_pc_valid drop immediately; after release state=RUN, stall follows inputs.

Source files
------------

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Central sequencer for the 5-stage core (pc, if_id, id_ex, ex_mem,
//            mem_wb). Merges per-stage stall requests into a stall vector,
//            sequences exception/redirect recovery (flush, then steer the pc
//            to the handler address until fetch accepts it) and runs a
//            watchdog over long-lasting stalls.
// Ports    :
//   i_clk             core clock, rising edge
//   i_rst_n           asynchronous reset, active-low
//   i_stallreq_if     fetch waiting on instruction memory
//   i_stallreq_id     load-use hazard in decode
//   i_stallreq_ex     multi-cycle op busy in execute
//   i_stallreq_mem    data memory wait
//   i_excp_req        exception/redirect request from the mem stage
//   i_excp_pc[31:0]   handler/target address, valid with i_excp_req
//   o_stall[5:0]      [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]always 0
//   o_flush           clear all stage registers
//   o_new_pc[31:0]    redirect address for the pc register
//   o_new_pc_valid    pc must load o_new_pc this cycle
//   o_stall_timeout   one-cycle watchdog expiry pulse
//   o_busy            sequencer is not in RUN
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int FLUSH_CYCLES  = 1,    // 1..15
  parameter int STALL_TIMEOUT = 255   // 1..255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stallreq_if,
  input  logic        i_stallreq_id,
  input  logic        i_stallreq_ex,
  input  logic        i_stallreq_mem,
  input  logic        i_excp_req,
  input  logic [31:0] i_excp_pc,
  output logic [5:0]  o_stall,
  output logic        o_flush,
  output logic [31:0] o_new_pc,
  output logic        o_new_pc_valid,
  output logic        o_stall_timeout,
  output logic        o_busy
);

  // A stage stall also holds every stage upstream of it.
  localparam logic [5:0] c_MASK_IF   = 6'b000011;
  localparam logic [5:0] c_MASK_ID   = 6'b000111;
  localparam logic [5:0] c_MASK_EX   = 6'b001111;
  localparam logic [5:0] c_MASK_MEM  = 6'b011111;
  localparam logic [3:0] c_FCNT_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] c_SCNT_LAST = 8'(STALL_TIMEOUT - 1);
  localparam logic [7:0] c_SCNT_SAT  = 8'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_fcnt;
  logic [7:0]  r_scnt;
  logic [31:0] r_new_pc;
  logic        r_flush;
  logic        r_redir;
  logic        r_busy;

  logic [5:0]  w_req_mask;
  logic        w_run;
  logic [5:0]  w_stall;
  logic        w_stalled;
  logic        w_timeout;

  assign w_req_mask = ({6{i_stallreq_if}}  & c_MASK_IF)
                    | ({6{i_stallreq_id}}  & c_MASK_ID)
                    | ({6{i_stallreq_ex}}  & c_MASK_EX)
                    | ({6{i_stallreq_mem}} & c_MASK_MEM);

  assign w_run = (r_state == ST_RUN);

  // Stall is combinational so a request holds the pipeline in the same cycle.
  // Gating with i_rst_n keeps every output at 0 while reset is asserted.
  assign w_stall   = (i_rst_n && w_run) ? w_req_mask : 6'b000000;
  assign w_stalled = |w_stall;
  assign w_timeout = w_stalled && (r_scnt == c_SCNT_LAST);

  // --------------------------------------------------------------------------
  // Recovery sequencer; flag outputs are registered alongside the state.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_RUN;
      r_fcnt   <= 4'd0;
      r_new_pc <= 32'd0;
      r_flush  <= 1'b0;
      r_redir  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (i_excp_req) begin
            r_state  <= ST_FLUSH;
            r_new_pc <= i_excp_pc;
            r_fcnt   <= 4'd0;
            r_flush  <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        ST_FLUSH: begin
          // All requests, including a new excp_req, are ignored here.
          r_fcnt <= r_fcnt + 4'd1;
          if (r_fcnt == c_FCNT_LAST) begin
            r_state <= ST_REDIR;
            r_flush <= 1'b0;
            r_redir <= 1'b1;
          end
        end
        ST_REDIR: begin
          // Hold the redirect until fetch is able to take the new pc.
          if (!i_stallreq_if) begin
            r_state <= ST_RUN;
            r_redir <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_flush <= 1'b0;
          r_redir <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stall watchdog. Counts consecutive stalled RUN cycles; the counter stops
  // one past the pulse value so exactly one pulse is issued per stall episode.
  // Leaving RUN (excp_req in RUN) clears it.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scnt <= 8'd0;
    end else if (w_stalled && !i_excp_req) begin
      if (r_scnt != c_SCNT_SAT) begin
        r_scnt <= r_scnt + 8'd1;
      end
    end else begin
      r_scnt <= 8'd0;
    end
  end

  assign o_stall         = w_stall;
  assign o_flush         = r_flush;
  assign o_new_pc        = r_new_pc;
  assign o_new_pc_valid  = r_redir;
  assign o_stall_timeout = w_timeout;
  assign o_busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Directed self-checking bench for pipeline_ctrl. Instance u_dut
//            uses FLUSH_CYCLES=1 / STALL_TIMEOUT=4; instance u_dut3 shares
//            the inputs and uses FLUSH_CYCLES=3 to check the flush length.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sif, sid, sex, smem;
  logic        excp;
  logic [31:0] excp_pc;

  logic [5:0]  stall,  stall3;
  logic        flush,  flush3;
  logic [31:0] new_pc, new_pc3;
  logic        npv,    npv3;
  logic        tmo,    tmo3;
  logic        busy,   busy3;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_stallreq_if(sif), .i_stallreq_id(sid), .i_stallreq_ex(sex), .i_stallreq_mem(smem),
    .i_excp_req(excp), .i_excp_pc(excp_pc),
    .o_stall(stall), .o_flush(flush), .o_new_pc(new_pc), .o_new_pc_valid(npv),
    .o_stall_timeout(tmo), .o_busy(busy)
  );

  pipeline_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(255)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_stallreq_if(sif), .i_stallreq_id(sid), .i_stallreq_ex(sex), .i_stallreq_mem(smem),
    .i_excp_req(excp), .i_excp_pc(excp_pc),
    .o_stall(stall3), .o_flush(flush3), .o_new_pc(new_pc3), .o_new_pc_valid(npv3),
    .o_stall_timeout(tmo3), .o_busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; checks happen 1 later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sif = 1'b0; sid = 1'b1; sex = 1'b1; smem = 1'b0;
    excp = 1'b1; excp_pc = 32'hDEAD_BEEF;
    #3;
    checks++;
    if ({stall, flush, npv, tmo, busy} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outs stall=%b flush=%b npv=%b tmo=%b busy=%b required all 0",
               stall, flush, npv, tmo, busy);
    end
    checks++;
    if (new_pc !== 32'd0) begin
      errors++; $display("FAIL reset_new_pc got=%h required=%h", new_pc, 32'd0);
    end
    step();
    #1;
    checks++;
    if ({stall, flush, npv, busy, new_pc} !== 41'd0) begin
      errors++;
      $display("FAIL reset_held stall=%b flush=%b npv=%b busy=%b new_pc=%h required all 0",
               stall, flush, npv, busy, new_pc);
    end
    sid = 1'b0; sex = 1'b0; excp = 1'b0; excp_pc = 32'd0;
    rst_n = 1'b1;
    step();
    #1;
    checks++;
    if ({stall, busy, flush3, busy3} !== 9'd0) begin
      errors++;
      $display("FAIL reset_release stall=%b busy=%b flush3=%b busy3=%b required 0",
               stall, busy, flush3, busy3);
    end
  endtask

  task automatic test_flush_len();
    step();
    excp = 1'b1; excp_pc = 32'h0000_0ABC;
    #1;
    checks++;
    if (flush3 !== 1'b0) begin
      errors++; $display("FAIL flen_excp_cycle flush3=%b required=0", flush3);
    end
    step();
    excp = 1'b0; excp_pc = 32'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (flush3 !== 1'b1 || busy3 !== 1'b1 || npv3 !== 1'b0) begin
        errors++;
        $display("FAIL flen_flush%0d flush3=%b busy3=%b npv3=%b required 1 1 0",
                 i, flush3, busy3, npv3);
      end
      step();
    end
    #1;
    checks++;
    if (flush3 !== 1'b0 || npv3 !== 1'b1 || new_pc3 !== 32'h0000_0ABC) begin
      errors++;
      $display("FAIL flen_redir flush3=%b npv3=%b new_pc3=%h required 0 1 00000abc",
               flush3, npv3, new_pc3);
    end
    step();
    #1;
    checks++;
    if (busy3 !== 1'b0 || npv3 !== 1'b0) begin
      errors++; $display("FAIL flen_run busy3=%b npv3=%b required 0 0", busy3, npv3);
    end
  endtask

  task automatic test_stall_merge();
    step();
    sid = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b000111) begin
      errors++; $display("FAIL merge_id stall=%b required=%b", stall, 6'b000111);
    end
    step();
    smem = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b011111) begin
      errors++; $display("FAIL merge_id_mem stall=%b required=%b", stall, 6'b011111);
    end
    step();
    sid = 1'b0; smem = 1'b0;
    #1;
    checks++;
    if (stall !== 6'b000000) begin
      errors++; $display("FAIL merge_none stall=%b required=%b", stall, 6'b000000);
    end
    step();
    sif = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b000011) begin
      errors++; $display("FAIL merge_if stall=%b required=%b", stall, 6'b000011);
    end
    step();
    sif = 1'b0; sex = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b001111) begin
      errors++; $display("FAIL merge_ex stall=%b required=%b", stall, 6'b001111);
    end
    step();
    sex = 1'b0;
    #1;
  endtask

  task automatic test_redirect();
    step();
    excp = 1'b1; excp_pc = 32'h0000_0100; sid = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b000111 || flush !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL redir_excp_cycle stall=%b flush=%b busy=%b required 000111 0 0",
               stall, flush, busy);
    end
    step();
    excp = 1'b0; excp_pc = 32'd0; sid = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b1 || busy !== 1'b1 || npv !== 1'b0 || stall !== 6'd0) begin
      errors++;
      $display("FAIL redir_flush flush=%b busy=%b npv=%b stall=%b required 1 1 0 000000",
               flush, busy, npv, stall);
    end
    step();
    #1;
    checks++;
    if (flush !== 1'b0 || npv !== 1'b1 || new_pc !== 32'h0000_0100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL redir_valid flush=%b npv=%b new_pc=%h busy=%b required 0 1 00000100 1",
               flush, npv, new_pc, busy);
    end
    step();
    #1;
    checks++;
    if (busy !== 1'b0 || npv !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL redir_run busy=%b npv=%b flush=%b required 0 0 0", busy, npv, flush);
    end
  endtask

  task automatic test_fetch_wait();
    step();
    excp = 1'b1; excp_pc = 32'h0000_0100;
    step();
    excp = 1'b0; excp_pc = 32'd0;
    #1;
    checks++;
    if (flush !== 1'b1) begin
      errors++; $display("FAIL fwait_flush flush=%b required=1", flush);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      sif = (i < 3);
      #1;
      checks++;
      if (npv !== 1'b1 || stall !== 6'd0 || new_pc !== 32'h0000_0100) begin
        errors++;
        $display("FAIL fwait_redir%0d npv=%b stall=%b new_pc=%h required 1 000000 00000100",
                 i, npv, stall, new_pc);
      end
    end
    step();
    sif = 1'b1;
    #1;
    checks++;
    if (npv !== 1'b0 || busy !== 1'b0 || stall !== 6'b000011) begin
      errors++;
      $display("FAIL fwait_run npv=%b busy=%b stall=%b required 0 0 000011", npv, busy, stall);
    end
    step();
    sif = 1'b0;
    #1;
  endtask

  task automatic test_ignored_events();
    step();
    excp = 1'b1; excp_pc = 32'h0000_0100;
    step();
    excp = 1'b1; excp_pc = 32'h0000_0200; sex = 1'b1;
    #1;
    checks++;
    if (stall !== 6'd0 || flush !== 1'b1 || new_pc !== 32'h0000_0100) begin
      errors++;
      $display("FAIL ign_flush stall=%b flush=%b new_pc=%h required 000000 1 00000100",
               stall, flush, new_pc);
    end
    step();
    sex = 1'b0;
    #1;
    checks++;
    if (npv !== 1'b1 || new_pc !== 32'h0000_0100 || stall !== 6'd0) begin
      errors++;
      $display("FAIL ign_redir npv=%b new_pc=%h stall=%b required 1 00000100 000000",
               npv, new_pc, stall);
    end
    step();
    excp = 1'b0; excp_pc = 32'd0;
    #1;
    checks++;
    if (busy !== 1'b0 || new_pc !== 32'h0000_0100) begin
      errors++;
      $display("FAIL ign_run busy=%b new_pc=%h required 0 00000100", busy, new_pc);
    end
  endtask

  task automatic test_watchdog();
    for (int k = 1; k <= 10; k++) begin
      step();
      sex = 1'b1;
      #1;
      checks++;
      if (tmo !== (k == 4) || stall !== 6'b001111) begin
        errors++;
        $display("FAIL wdog_a%0d tmo=%b stall=%b required %b 001111", k, tmo, stall, (k == 4));
      end
    end
    step();
    sex = 1'b0;
    #1;
    checks++;
    if (tmo !== 1'b0 || stall !== 6'd0) begin
      errors++; $display("FAIL wdog_drop tmo=%b stall=%b required 0 000000", tmo, stall);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      sex = 1'b1;
      #1;
      checks++;
      if (tmo !== (k == 4)) begin
        errors++; $display("FAIL wdog_b%0d tmo=%b required=%b", k, tmo, (k == 4));
      end
    end
    step();
    sex = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_flush();
    step();
    excp = 1'b1; excp_pc = 32'h0000_0400;
    step();
    excp = 1'b0; excp_pc = 32'd0; sid = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rmf_pre flush=%b busy=%b required 1 1", flush, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (flush !== 1'b0 || busy !== 1'b0 || npv !== 1'b0 || stall !== 6'd0 || new_pc !== 32'd0) begin
      errors++;
      $display("FAIL rmf_async flush=%b busy=%b npv=%b stall=%b new_pc=%h required all 0",
               flush, busy, npv, stall, new_pc);
    end
    step();
    rst_n = 1'b1;
    step();
    #1;
    checks++;
    if (stall !== 6'b000111 || busy !== 1'b0 || flush !== 1'b0 || npv !== 1'b0 ||
        new_pc !== 32'd0) begin
      errors++;
      $display("FAIL rmf_after stall=%b busy=%b flush=%b npv=%b new_pc=%h required 000111 0 0 0 0",
               stall, busy, flush, npv, new_pc);
    end
    step();
    sid = 1'b0;
    #1;
  endtask

  initial begin
    test_reset();
    test_flush_len();
    test_stall_merge();
    test_redirect();
    test_fetch_wait();
    test_ignored_events();
    test_watchdog();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
